// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle shift unit for the RV32I shift instructions (SLL/SRL/SRA and the
// immediate forms). Each cycle in SHIFT moves the operand one bit position, so
// latency is shamt+1 cycles in exchange for a much smaller datapath than a
// barrel shifter.
//
// Ports
//   clk     : rising-edge clock
//   rst     : asynchronous, active-high reset
//   start   : shift request, accepted only while busy is low and kill is low
//   kill    : pipeline flush, aborts any in-flight shift (wins over start)
//   op_a    : operand to shift (rs1)
//   shamt   : shift amount (imm[4:0] or rs2[4:0]), taken modulo WIDTH
//   funct3  : 3'b001 left shift, 3'b101 right shift, anything else pass-through
//   arith   : for right shifts, 1 = arithmetic (SRA), 0 = logical (SRL)
//   busy    : high exactly during SHIFT cycles
//   done    : one-cycle pulse in the cycle the result is valid
//   result  : shifted value, stable from done until the next accepted start
//
// Parameters
//   WIDTH   : operand/result width
//   SHAMT_W : shift-amount width, expected to be log2(WIDTH)
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               kill,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [2:0]         funct3,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_SLL  = 2'd1,
        MODE_SRL  = 2'd2,
        MODE_SRA  = 2'd3
    } mode_t;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    mode_t              start_mode;
    logic [SHAMT_W-1:0] start_cnt;
    logic               accept;

    // One bit position per call. SRA re-injects the current MSB, which is the
    // original sign bit because the MSB never changes during an SRA sequence.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                    input mode_t m);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SLL: r = {v[WIDTH-2:0], 1'b0};
            MODE_SRL: r = {1'b0, v[WIDTH-1:1]};
            MODE_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
            default:  r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        start_mode = MODE_PASS;
        if (funct3 == 3'b001) begin
            start_mode = MODE_SLL;
        end else if (funct3 == 3'b101) begin
            start_mode = arith ? MODE_SRA : MODE_SRL;
        end
        // Pass-through completes in one cycle regardless of shamt.
        start_cnt = (start_mode == MODE_PASS) ? '0 : shamt;
    end

    // busy_q is high only in SHIFT, so !busy_q covers both IDLE and DONE.
    assign accept = start & ~busy_q & ~kill;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        if (kill) begin
            // Flush: drop back to IDLE, keep whatever partial result exists.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    result_d = shift_step(result_q, mode_q);
                    cnt_d    = cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept, giving back-to-back issue.
                    if (accept) begin
                        result_d = op_a;
                        mode_d   = start_mode;
                        cnt_d    = start_cnt;
                        if (start_cnt != '0) begin
                            state_d = ST_SHIFT;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_PASS;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle shift unit for the RV32I shift instructions (SLL/SRL/SRA and SLLI/SRLI/SRAI). It sits in the execute stage directly downstream of the immediate generator. For immediate shifts it consumes the sign-extended immediate's low 5 bits as the shift amount; for register shifts it consumes rs2[4:0]. It shifts one bit position per cycle under a start/busy/done handshake, trading latency for area compared with a barrel shifter.

## Interface
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a shift; accepted only when busy==0.
- kill  input  1  pipeline flush; aborts any in-flight shift.
- op_a  input  WIDTH  value to shift (rs1).
- shamt  input  SHAMT_W  shift amount (imm_val[4:0] or rs2[4:0]).
- funct3  input  3  001 = left shift; 101 = right shift; any other value = pass-through.
- arith  input  1  instruction bit 30; for funct3 101, 1 = SRA, 0 = SRL; ignored otherwise.
- busy  output  1  high while shifting.
- done  output  1  one-cycle pulse when result is valid.
- result  output  WIDTH  shifted value; holds its value from done until the next accepted start.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: start==1 and busy==0 (state IDLE or DONE) and kill==0.
  - Latch op_a into the result register, shamt into the down-counter cnt, and the mode (SLL/SRL/SRA/PASS).
  - PASS mode (funct3 not 001/101) forces cnt to 0.
- From IDLE/DONE on accept: go to SHIFT if cnt!=0, otherwise go to DONE.
- SHIFT, each cycle:
  - SLL: result <= {result[WIDTH-2:0], 1'b0}.
  - SRL: result <= {1'b0, result[WIDTH-1:1]}.
  - SRA: result <= {result[WIDTH-1], result[WIDTH-1:1]}.
  - cnt <= cnt-1. When cnt==1 at the edge, next state is DONE.
- DONE: done=1 for exactly this cycle. Next state is IDLE, or SHIFT/DONE if a new start is accepted in this cycle (back-to-back issue).
- start while busy==1: ignored, no latching, no error.
- kill==1 in any state: next state IDLE, done not asserted, result keeps its partial value. kill has priority over start in the same cycle.
- Arithmetic rules:
  - The shift amount is taken modulo WIDTH (only SHAMT_W bits are used).
  - SRA replicates the original bit WIDTH-1 throughout.
  - No other width extension.
- Reset (asynchronous): state IDLE, cnt 0, mode PASS, result 0, busy 0, done 0. Reset mid-shift discards the operation immediately.

## Timing
- busy is registered: high exactly during SHIFT cycles.
- done is registered: high exactly in the DONE cycle.
- Start accepted at cycle T:
  - done is asserted in cycle T+shamt+1; T+1 when shamt==0 or in PASS mode.
  - busy is high in cycles T+1 .. T+shamt.
- result is valid in the done cycle and stays stable until the edge after the next accepted start.
- Throughput: a new start is accepted in the DONE cycle, so the issue interval is shamt+1 cycles.
- Inputs are sampled only on the accepting edge; they may change freely afterwards.

## Test plan
- SLL: op_a=0x00000001, shamt=4, funct3=001 at T -> busy high T+1..T+4; done at T+5; result=0x00000010.
- SRA/SRL: op_a=0x80000000, shamt=31, funct3=101.
  - arith=1 -> done at T+32, result=0xFFFFFFFF.
  - arith=0 -> result=0x00000001.
- Zero/pass: shamt=0 with funct3=101 -> done at T+1, result=op_a. funct3=000 with shamt=7 -> done at T+1, result=op_a.
- Busy start: start pulsed again in T+2 during the SLL-by-4 case with op_a=0xFFFF -> ignored; result still 0x00000010 at T+5. Back-to-back start in the done cycle is accepted.
- Kill: SLL by 10 started at T, kill at T+3 -> state IDLE at T+4, done never asserts. A new start at T+4 runs normally.
- Reset: assert rst asynchronously mid-SHIFT -> busy, done and result are 0 immediately. After release, a shift of 0x3 by 1 (SLL) gives 0x6 at T+2.
